fail_logger: RTL and testbench

// - Consumes per-channel error strobes and error addresses from the RAM test controller (even/odd channels).
// - Counts failures per channel and logs failing addresses, tagged by channel, into a small FIFO for readout.
// - Sits in the clk_slow_even domain between the RAM test controller and the readout/display logic.

---
 rtl/fail_log_pkg.sv | 16 +
 rtl/fail_logger_if.sv | 29 ++
 rtl/fail_log_fifo.sv | 58 +++++
 rtl/fail_logger.sv | 112 +++++++++++
 tb/tb_fail_logger.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fail_log_pkg.sv
// Shared types for the failure logger: FSM states, default widths, log entry layout.
package fail_log_pkg;
  localparam int FL_ADDR_W = 10;
  localparam int FL_CNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN} fl_state_e;

  typedef struct packed {
    logic                 chan;
    logic [FL_ADDR_W-1:0] addr;
  } log_entry_t;

  function automatic log_entry_t mk_entry(input logic chan, input logic [FL_ADDR_W-1:0] addr);
    mk_entry = '{chan: chan, addr: addr};
  endfunction
endpackage

// File: rtl/fail_logger_if.sv
// Strobe inputs, readout handshake and status outputs of fail_logger.
interface fail_logger_if #(
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16,
  parameter int LOG_DEPTH = 16
);
  logic                         arm;
  logic                         error_1;
  logic                         error_2;
  logic [ADDR_W-1:0]            error_address_1;
  logic [ADDR_W-1:0]            error_address_2;
  logic                         rd_en;
  logic                         rd_valid;
  logic [ADDR_W:0]              rd_data;
  logic [$clog2(LOG_DEPTH):0]   log_count;
  logic [CNT_W-1:0]             fail_cnt_1;
  logic [CNT_W-1:0]             fail_cnt_2;
  logic                         dropped;
  logic                         running;

  modport master (
    output arm, error_1, error_2, error_address_1, error_address_2, rd_en,
    input  rd_valid, rd_data, log_count, fail_cnt_1, fail_cnt_2, dropped, running
  );
  modport slave (
    input  arm, error_1, error_2, error_address_1, error_address_2, rd_en,
    output rd_valid, rd_data, log_count, fail_cnt_1, fail_cnt_2, dropped, running
  );
endinterface

// File: rtl/fail_log_fifo.sv
// Dual-push / single-pop FIFO; push_b lands after push_a when both fire. Caller gates pushes on free space.
module fail_log_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push_a,
  input  logic [W-1:0]             i_data_a,
  input  logic                     i_push_b,
  input  logic [W-1:0]             i_data_b,
  input  logic                     i_pop,
  output logic                     o_rd_valid,
  output logic [W-1:0]             o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!i_clr) begin
      if (i_push_a) r_mem[r_wp] <= i_data_a;
      if (i_push_b) r_mem[r_wp + AW'(i_push_a)] <= i_data_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else if (i_clr) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      r_wp       <= r_wp + AW'(i_push_a) + AW'(i_push_b);
      r_count    <= r_count + CW'(i_push_a) + CW'(i_push_b) - CW'(w_pop);
      o_rd_valid <= w_pop;
      if (w_pop) begin
        o_rd_data <= r_mem[r_rp];
        r_rp      <= r_rp + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fail_logger.sv
// Per-channel failure counter and address logger with arm/settle/run control.
// Optional FAIL_LOG_DEDUP_EN: skip logging a repeat of a channel's last logged address.
module fail_logger
  import fail_log_pkg::*;
#(
  parameter int ADDR_W    = FL_ADDR_W,
  parameter int CNT_W     = FL_CNT_W,
  parameter int LOG_DEPTH = 16,
  parameter int SETTLE    = 5
) (
  input logic          clk_slow_even,
  input logic          reset,
  fail_logger_if.slave bus
);
  localparam int CW = $clog2(LOG_DEPTH) + 1;
  localparam int SW = $clog2(SETTLE + 1);

  fl_state_e     r_state;
  logic [SW-1:0] r_settle;
  logic [CNT_W-1:0] r_cnt1, r_cnt2;
  logic          r_dropped, r_running;
  logic          w_run, w_dup1, w_dup2, w_want1, w_want2, w_wr1, w_wr2, w_drop;
  logic [CW-1:0] w_count, w_free;

`ifdef FAIL_LOG_DEDUP_EN
  logic [ADDR_W-1:0] r_last1, r_last2;
  logic              r_lv1, r_lv2;

  assign w_dup1 = r_lv1 && (r_last1 == bus.error_address_1);
  assign w_dup2 = r_lv2 && (r_last2 == bus.error_address_2);

  always_ff @(posedge clk_slow_even or posedge reset) begin
    if (reset) begin
      r_last1 <= '0; r_lv1 <= 1'b0;
      r_last2 <= '0; r_lv2 <= 1'b0;
    end else if (bus.arm) begin
      r_last1 <= '0; r_lv1 <= 1'b0;
      r_last2 <= '0; r_lv2 <= 1'b0;
    end else begin
      if (w_wr1) begin r_last1 <= bus.error_address_1; r_lv1 <= 1'b1; end
      if (w_wr2) begin r_last2 <= bus.error_address_2; r_lv2 <= 1'b1; end
    end
  end
`else
  assign w_dup1 = 1'b0;
  assign w_dup2 = 1'b0;
`endif

  // Free space is taken before this cycle's pop, so a pop only helps next cycle.
  assign w_run   = (r_state == S_RUN) && !bus.arm;
  assign w_want1 = w_run && bus.error_1 && !w_dup1;
  assign w_want2 = w_run && bus.error_2 && !w_dup2;
  assign w_free  = CW'(LOG_DEPTH) - w_count;
  assign w_wr1   = w_want1 && (w_free != '0);
  assign w_wr2   = w_want2 && (w_free > CW'(w_wr1));
  assign w_drop  = (w_want1 && !w_wr1) || (w_want2 && !w_wr2);

  always_ff @(posedge clk_slow_even or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_settle  <= '0;
      r_cnt1    <= '0;
      r_cnt2    <= '0;
      r_dropped <= 1'b0;
      r_running <= 1'b0;
    end else if (bus.arm) begin
      r_state   <= S_SETTLE;
      r_settle  <= '0;
      r_cnt1    <= '0;
      r_cnt2    <= '0;
      r_dropped <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        S_SETTLE: begin
          if (r_settle == SW'(SETTLE - 1)) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_RUN: begin
          if (bus.error_1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
          if (bus.error_2 && (r_cnt2 != '1)) r_cnt2 <= r_cnt2 + 1'b1;
          if (w_drop) r_dropped <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  fail_log_fifo #(.W(ADDR_W + 1), .DEPTH(LOG_DEPTH)) u_fifo (
    .clk        (clk_slow_even),
    .rst        (reset),
    .i_clr      (bus.arm),
    .i_push_a   (w_wr1),
    .i_data_a   ({1'b0, bus.error_address_1}),
    .i_push_b   (w_wr2),
    .i_data_b   ({1'b1, bus.error_address_2}),
    .i_pop      (bus.rd_en && !bus.arm),
    .o_rd_valid (bus.rd_valid),
    .o_rd_data  (bus.rd_data),
    .o_count    (w_count)
  );

  assign bus.log_count  = w_count;
  assign bus.fail_cnt_1 = r_cnt1;
  assign bus.fail_cnt_2 = r_cnt2;
  assign bus.dropped    = r_dropped;
  assign bus.running    = r_running;
endmodule

// File: tb/tb_fail_logger.sv
// Directed bench for fail_logger (CNT_W=4 so saturation is reachable); covers both FAIL_LOG_DEDUP_EN builds.
module tb_fail_logger;
  import fail_log_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fail_logger_if #(.ADDR_W(10), .CNT_W(4), .LOG_DEPTH(16)) bus ();

  fail_logger #(.ADDR_W(10), .CNT_W(4), .LOG_DEPTH(16), .SETTLE(5)) dut (
    .clk_slow_even (clk),
    .reset         (rst),
    .bus           (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic e1, input logic [9:0] a1, input logic e2, input logic [9:0] a2);
    bus.error_1 = e1; bus.error_address_1 = a1;
    bus.error_2 = e2; bus.error_address_2 = a2;
  endtask

  // arm, then sit through the 5 settle cycles; returns in the first RUN cycle
  task automatic arm_run();
    bus.arm = 1'b1;
    cyc();
    bus.arm = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic pop_chk(input string tag, input log_entry_t exp, input int cnt_after);
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    chk({tag, "_cnt"}, 32'(bus.log_count), 32'(cnt_after));
  endtask

  initial begin
    rst = 1'b1;
    bus.arm = 1'b0; bus.rd_en = 1'b0;
    strobe(1'b0, '0, 1'b0, '0);
    repeat (2) cyc();
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_count", 32'(bus.log_count), 32'd0);
    chk("rst_cnt1", 32'(bus.fail_cnt_1), 32'd0);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_dropped", 32'(bus.dropped), 32'd0);
    rst = 1'b0;

    // IDLE ignores strobes
    strobe(1'b1, 10'h0AA, 1'b1, 10'h0BB);
    cyc();
    strobe(1'b0, '0, 1'b0, '0);
    chk("idle_cnt1", 32'(bus.fail_cnt_1), 32'd0);
    chk("idle_count", 32'(bus.log_count), 32'd0);

    // arm cycle and settle cycles 1..5 ignore strobes
    bus.arm = 1'b1;
    strobe(1'b1, 10'h3FF, 1'b0, '0);
    cyc();
    bus.arm = 1'b0;
    chk("settle_running", 32'(bus.running), 32'd0);
    repeat (5) cyc();
    chk("settle_cnt1", 32'(bus.fail_cnt_1), 32'd0);
    chk("settle_count", 32'(bus.log_count), 32'd0);
    chk("run_running", 32'(bus.running), 32'd1);

    // cycle 6 onward: three ch1 strobes
    strobe(1'b1, 10'h012, 1'b0, '0); cyc();
    strobe(1'b1, 10'h013, 1'b0, '0); cyc();
    strobe(1'b1, 10'h014, 1'b0, '0); cyc();
    strobe(1'b0, '0, 1'b0, '0);
    chk("seq_cnt1", 32'(bus.fail_cnt_1), 32'd3);
    chk("seq_count", 32'(bus.log_count), 32'd3);
    pop_chk("pop0", mk_entry(1'b0, 10'h012), 2);
    pop_chk("pop1", mk_entry(1'b0, 10'h013), 1);
    pop_chk("pop2", mk_entry(1'b0, 10'h014), 0);
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
    chk("empty_valid", 32'(bus.rd_valid), 32'd0);
    chk("empty_hold", 32'(bus.rd_data), 32'(mk_entry(1'b0, 10'h014)));

    // both channels in one cycle
    arm_run();
    strobe(1'b1, 10'h100, 1'b1, 10'h200);
    cyc();
    strobe(1'b0, '0, 1'b0, '0);
    chk("both_cnt1", 32'(bus.fail_cnt_1), 32'd1);
    chk("both_cnt2", 32'(bus.fail_cnt_2), 32'd1);
    pop_chk("both_pop0", mk_entry(1'b0, 10'h100), 1);
    pop_chk("both_pop1", mk_entry(1'b1, 10'h200), 0);

    // 15 entries, then both strobes with one slot free
    arm_run();
    for (int i = 0; i < 15; i++) begin
      strobe(1'b1, 10'(i), 1'b0, '0);
      cyc();
    end
    strobe(1'b0, '0, 1'b0, '0);
    chk("fill_count", 32'(bus.log_count), 32'd15);
    chk("fill_dropped", 32'(bus.dropped), 32'd0);
    strobe(1'b1, 10'h055, 1'b1, 10'h066);
    cyc();
    strobe(1'b0, '0, 1'b0, '0);
    chk("full_count", 32'(bus.log_count), 32'd16);
    chk("full_dropped", 32'(bus.dropped), 32'd1);
    chk("full_cnt1_sat", 32'(bus.fail_cnt_1), 32'd15);
    chk("full_cnt2", 32'(bus.fail_cnt_2), 32'd1);

    // arm together with rd_en: arm wins
    bus.arm = 1'b1; bus.rd_en = 1'b1;
    cyc();
    bus.arm = 1'b0; bus.rd_en = 1'b0;
    chk("arm_valid", 32'(bus.rd_valid), 32'd0);
    chk("arm_count", 32'(bus.log_count), 32'd0);
    chk("arm_cnt1", 32'(bus.fail_cnt_1), 32'd0);
    chk("arm_cnt2", 32'(bus.fail_cnt_2), 32'd0);
    chk("arm_dropped", 32'(bus.dropped), 32'd0);
    chk("arm_running", 32'(bus.running), 32'd0);

    // 20 ch1 strobes saturate the 4-bit counter; log caps at 16
    repeat (5) cyc();
    for (int i = 0; i < 20; i++) begin
      strobe(1'b1, 10'(10'h040 + i), 1'b0, '0);
      cyc();
    end
    strobe(1'b0, '0, 1'b0, '0);
    chk("sat_cnt1", 32'(bus.fail_cnt_1), 32'd15);
    chk("sat_count", 32'(bus.log_count), 32'd16);
    chk("sat_dropped", 32'(bus.dropped), 32'd1);

    // pop and push in the same cycle while full: the push is still refused
    bus.rd_en = 1'b1;
    strobe(1'b1, 10'h077, 1'b0, '0);
    cyc();
    bus.rd_en = 1'b0;
    strobe(1'b0, '0, 1'b0, '0);
    chk("pp_count", 32'(bus.log_count), 32'd15);
    chk("pp_data", 32'(bus.rd_data), 32'(mk_entry(1'b0, 10'h040)));

    // one free slot now; a push in the next cycle fits
    strobe(1'b1, 10'h078, 1'b0, '0);
    cyc();
    strobe(1'b0, '0, 1'b0, '0);
    chk("refill_count", 32'(bus.log_count), 32'd16);

    // repeated address
    arm_run();
    strobe(1'b1, 10'h0AA, 1'b0, '0); cyc();
    strobe(1'b1, 10'h0AA, 1'b0, '0); cyc();
    strobe(1'b1, 10'h0AB, 1'b0, '0); cyc();
    strobe(1'b0, '0, 1'b0, '0);
    chk("dup_cnt1", 32'(bus.fail_cnt_1), 32'd3);
`ifdef FAIL_LOG_DEDUP_EN
    chk("dup_count", 32'(bus.log_count), 32'd2);
    pop_chk("dup_pop0", mk_entry(1'b0, 10'h0AA), 1);
    pop_chk("dup_pop1", mk_entry(1'b0, 10'h0AB), 0);
`else
    chk("dup_count", 32'(bus.log_count), 32'd3);
    pop_chk("dup_pop0", mk_entry(1'b0, 10'h0AA), 2);
    pop_chk("dup_pop1", mk_entry(1'b0, 10'h0AA), 1);
    pop_chk("dup_pop2", mk_entry(1'b0, 10'h0AB), 0);
`endif
    chk("dup_dropped", 32'(bus.dropped), 32'd0);

    // async reset mid-RUN clears outputs without a clock edge
    strobe(1'b1, 10'h0C0, 1'b1, 10'h0C1);
    cyc();
    strobe(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk("ar_running", 32'(bus.running), 32'd0);
    chk("ar_count", 32'(bus.log_count), 32'd0);
    chk("ar_cnt1", 32'(bus.fail_cnt_1), 32'd0);
    chk("ar_cnt2", 32'(bus.fail_cnt_2), 32'd0);
    chk("ar_data", 32'(bus.rd_data), 32'd0);
    chk("ar_valid", 32'(bus.rd_valid), 32'd0);
    cyc();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
